// File: rtl/axi_slv_mem.sv
// AXI3 slave backed by a word-addressed internal memory.
// Independent write (WIdle/WData/WResp) and read (RIdle/RData) FSMs, one outstanding
// transaction each. FIXED/INCR/WRAP bursts with byte strobes. Whole-burst errors are
// detected at address accept; out-of-range beats return DECERR and are not written.
// Ports:
//   aclk_i, arstn_i            clock, asynchronous active-low reset
//   aw*_i / awready_o          write address channel (lock/cache/prot ignored)
//   w*_i / wready_o            write data channel
//   b*_o / bready_i            write response channel
//   ar*_i / arready_o          read address channel (lock/cache/prot ignored)
//   r*_o / rready_i            read data channel
module axi_slv_mem #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned SIZE_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                    aclk_i,
    input  logic                    arstn_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [LEN_WIDTH-1:0]    awlen_i,
    input  logic [SIZE_WIDTH-1:0]   awsize_i,
    input  logic [1:0]              awbrust_i,
    input  logic [1:0]              awlock_i,
    input  logic [3:0]              awcache_i,
    input  logic [2:0]              awprot_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ID_WIDTH-1:0]     wid_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrob_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [LEN_WIDTH-1:0]    arlen_i,
    input  logic [SIZE_WIDTH-1:0]   arsize_i,
    input  logic [1:0]              arbrust_i,
    input  logic [1:0]              arlock_i,
    input  logic [3:0]              arcache_i,
    input  logic [2:0]              arprot_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    localparam int unsigned STRB = DATA_WIDTH / 8;
    localparam int unsigned OFFS = $clog2(STRB);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MemBytes = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    logic unused_sideband;
    assign unused_sideband = ^{awlock_i, awcache_i, awprot_i, arlock_i, arcache_i, arprot_i};

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [LEN_WIDTH-1:0]  len,
                                                        input logic [SIZE_WIDTH-1:0] size,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] incr, aligned, wmask, nxt;
        incr    = ADDR_WIDTH'(1) << size;
        aligned = addr & ~(incr - 1'b1);
        // Wrap window is (len+1)<<size bytes; legal wrap lengths make it a power of two.
        wmask   = ((ADDR_WIDTH'(len) + 1'b1) << size) - 1'b1;
        case (burst)
            2'b00:   nxt = addr;
            2'b10:   nxt = (addr & ~wmask) | ((aligned + incr) & wmask);
            default: nxt = aligned + incr;
        endcase
        return nxt;
    endfunction

    function automatic logic burst_err(input logic [1:0]            burst,
                                       input logic [LEN_WIDTH-1:0]  len,
                                       input logic [SIZE_WIDTH-1:0] size);
        logic bad_wrap;
        bad_wrap = (len == '0) || ((len & (len + 1'b1)) != '0);
        return (burst == 2'b11) || ((32'd1 << size) > STRB) || ((burst == 2'b10) && bad_wrap);
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < MemBytes;
    endfunction

    // Response codes are ordered so that the numerically larger one is the worse one.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  ready_en_q;

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [LEN_WIDTH-1:0]  wlen_q, wlen_d;
    logic [SIZE_WIDTH-1:0] wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [LEN_WIDTH:0]    wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  mem_we;
    logic [1:0]            beat_resp;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [LEN_WIDTH-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d, rcnt_nxt;
    logic [SIZE_WIDTH-1:0] rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  ld_en, ld_err, ld_last;
    logic [ADDR_WIDTH-1:0] ld_addr;

    assign awready_o = ready_en_q && (w_state_q == WIdle);
    assign wready_o  = (w_state_q == WData);
    assign bvalid_o  = (w_state_q == WResp);
    assign bid_o     = wid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = ready_en_q && (r_state_q == RIdle);
    assign rvalid_o  = (r_state_q == RData);
    assign rid_o     = rid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        beat_resp = RespOkay;
        case (w_state_q)
            WIdle: begin
                if (awvalid_i && awready_o) begin
                    wid_d     = awid_i;
                    waddr_d   = awaddr_i;
                    wlen_d    = awlen_i;
                    wsize_d   = awsize_i;
                    wburst_d  = awbrust_i;
                    wcnt_d    = '0;
                    werr_d    = burst_err(awbrust_i, awlen_i, awsize_i);
                    bresp_d   = werr_d ? RespSlvErr : RespOkay;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (wvalid_i) begin
                    if (!werr_q) begin
                        if (!in_range(waddr_q)) beat_resp = RespDecErr;
                        else                    mem_we    = 1'b1;
                    end
                    if ((wid_i != wid_q) || (wlast_i != (wcnt_q == {1'b0, wlen_q}))) begin
                        beat_resp = resp_max(beat_resp, RespSlvErr);
                    end
                    bresp_d = resp_max(bresp_q, beat_resp);
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    // Saturate so overlong bursts never alias back onto beat len.
                    if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
                    if (wlast_i) w_state_d = WResp;
                end
            end
            WResp:   if (bready_i) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rcnt_nxt  = rcnt_q + 1'b1;
        ld_en     = 1'b0;
        ld_addr   = raddr_q;
        ld_err    = rerr_q;
        ld_last   = 1'b0;
        case (r_state_q)
            RIdle: begin
                if (arvalid_i && arready_o) begin
                    rid_d     = arid_i;
                    raddr_d   = araddr_i;
                    rlen_d    = arlen_i;
                    rsize_d   = arsize_i;
                    rburst_d  = arbrust_i;
                    rcnt_d    = '0;
                    rerr_d    = burst_err(arbrust_i, arlen_i, arsize_i);
                    ld_en     = 1'b1;
                    ld_addr   = araddr_i;
                    ld_err    = rerr_d;
                    ld_last   = (arlen_i == '0);
                    r_state_d = RData;
                end
            end
            RData: begin
                if (rready_i) begin
                    if (rlast_q) begin
                        r_state_d = RIdle;
                    end else begin
                        raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rcnt_d  = rcnt_nxt;
                        ld_en   = 1'b1;
                        ld_addr = raddr_d;
                        ld_last = (rcnt_nxt == rlen_q);
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
        // Memory is read combinationally here, so a same-cycle write returns old data.
        if (ld_en) begin
            rlast_d = ld_last;
            if (ld_err) begin
                rdata_d = '0;
                rresp_d = RespSlvErr;
            end else if (!in_range(ld_addr)) begin
                rdata_d = '0;
                rresp_d = RespDecErr;
            end else begin
                rdata_d = mem_q[ld_addr[OFFS +: IDXW]];
                rresp_d = RespOkay;
            end
        end
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ready_en_q <= 1'b0;
            w_state_q  <= WIdle;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
            bresp_q    <= '0;
            r_state_q  <= RIdle;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            w_state_q  <= w_state_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge aclk_i) begin
        for (int unsigned i = 0; i < STRB; i++) begin
            if (mem_we && wstrob_i[i]) mem_q[waddr_q[OFFS +: IDXW]][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Randomized bench for axi_slv_mem against a byte-array memory model and a per-beat
// address model; a single negedge process checks every R and B handshake.
module tb_axi_slv_mem;
    localparam int MEMB = 1024;

    logic        aclk = 1'b0, arstn = 1'b0;
    logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [3:0]  awlen = '0, arlen = '0, wstrob = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awbrust = '0, arbrust = '0, bresp, rresp;
    logic        awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rlast, rvalid;

    always #5 aclk = ~aclk;

    axi_slv_mem dut (
        .aclk_i(aclk), .arstn_i(arstn),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
        .awbrust_i(awbrust), .awlock_i(2'b00), .awcache_i(4'h0), .awprot_i(3'h0),
        .awvalid_i(awvalid), .awready_o(awready),
        .wid_i(wid), .wdata_i(wdata), .wstrob_i(wstrob), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
        .arbrust_i(arbrust), .arlock_i(2'b01), .arcache_i(4'h0), .arprot_i(3'h0),
        .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast),
        .rvalid_o(rvalid), .rready_i(rready)
    );

    typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rbeat_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

    int          nvec = 0, nerr = 0;
    logic [7:0]  mdl_mem [MEMB];
    logic [31:0] wdat [32];
    logic [3:0]  wstb [32];
    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] obs_rdata[$];
    logic [1:0]  obs_rresp[$];
    logic        obs_rlast[$];
    logic [1:0]  obs_bresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte address of beat n, written straight from the AXI burst definitions.
    function automatic logic [31:0] m_addr(input logic [31:0] start, input logic [3:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input int n);
        logic [31:0] sz, aligned, total, lower;
        sz      = 32'd1 << size;
        aligned = (start / sz) * sz;
        if (n == 0 || burst == 2'b00) return start;
        if (burst == 2'b10) begin
            total = (len + 32'd1) * sz;
            lower = (start / total) * total;
            return lower + ((aligned - lower + n * sz) % total);
        end
        return aligned + n * sz;
    endfunction

    function automatic bit m_err(input logic [1:0] burst, input logic [3:0] len,
                                 input logic [2:0] size);
        return burst == 2'b11 || (32'd1 << size) > 4 ||
               (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int b;
        b = int'(a / 4) * 4;
        return {mdl_mem[b+3], mdl_mem[b+2], mdl_mem[b+1], mdl_mem[b]};
    endfunction

    function automatic logic [1:0] rmax(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    initial begin : compare
        rbeat_t      e;
        bexp_t       eb;
        bit          r_hold;
        logic [38:0] held;
        r_hold = 0;
        forever begin
            @(negedge aclk);
            if (!arstn) begin
                r_hold = 0;
            end else begin
                if (rvalid) begin
                    if (r_hold) chk("r_stable", {rid, rdata, rresp, rlast}, held);
                    if (rready) begin
                        if (exp_r.size() == 0) begin
                            chk("r_unexpected", rvalid, 1'b0);
                        end else begin
                            e = exp_r.pop_front();
                            chk("rid", rid, e.id);
                            chk("rdata", rdata, e.data);
                            chk("rresp", rresp, e.resp);
                            chk("rlast", rlast, e.last);
                        end
                        obs_rdata.push_back(rdata);
                        obs_rresp.push_back(rresp);
                        obs_rlast.push_back(rlast);
                        r_hold = 0;
                    end else begin
                        r_hold = 1;
                        held   = {rid, rdata, rresp, rlast};
                    end
                end else begin
                    r_hold = 0;
                end
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        chk("b_unexpected", bvalid, 1'b0);
                    end else begin
                        eb = exp_b.pop_front();
                        chk("bid", bid, eb.id);
                        chk("bresp", bresp, eb.resp);
                    end
                    obs_bresp = bresp;
                end
            end
        end
    end

    // abort_after > 0 stops after that many accepted beats, leaving the slave in WDATA.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int bad_wid, input int abort_after, input bit gaps);
        bit          err;
        logic [1:0]  resp;
        logic [31:0] a, base;
        int          tmo;
        err  = m_err(burst, len, size);
        resp = err ? 2'b10 : 2'b00;
        awid = id; awaddr = addr; awlen = len; awsize = size; awbrust = burst; awvalid = 1;
        tmo = 0;
        @(negedge aclk);
        while (!awready && tmo < 50) begin tmo++; @(negedge aclk); end
        chk("aw_handshake", awready, 1'b1);
        @(posedge aclk); #1 awvalid = 0;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 0;
                @(posedge aclk); #1;
            end
            wvalid = 1; wdata = wdat[k]; wstrob = wstb[k]; wlast = (k == nbeats - 1);
            wid = (k == bad_wid) ? ~id : id;
            tmo = 0;
            @(negedge aclk);
            while (!wready && tmo < 50) begin tmo++; @(negedge aclk); end
            chk("w_handshake", wready, 1'b1);
            @(posedge aclk);
            a = m_addr(addr, len, size, burst, k);
            if (!err) begin
                if (a >= MEMB) begin
                    resp = rmax(resp, 2'b11);
                end else begin
                    base = a & ~32'd3;
                    for (int l = 0; l < 4; l++)
                        if (wstb[k][l]) mdl_mem[base+l] = wdat[k][8*l +: 8];
                end
            end
            if (wid != id || wlast != (k == int'(len))) resp = rmax(resp, 2'b10);
            #1;
            if (k + 1 == abort_after) begin
                wvalid = 0; wlast = 0;
                return;
            end
        end
        wvalid = 0; wlast = 0;
        exp_b.push_back('{id: id, resp: resp});
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        bready = 1;
        tmo = 0;
        @(negedge aclk);
        while (!bvalid && tmo < 50) begin tmo++; @(negedge aclk); end
        chk("b_handshake", bvalid, 1'b1);
        @(posedge aclk); #1 bready = 0;
    endtask

    // mode: 0 always ready, 1 ready every other cycle, 2 random ready.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int abort_after);
        bit          err;
        logic [31:0] a;
        int          tmo, got;
        rbeat_t      e;
        err = m_err(burst, len, size);
        arid = id; araddr = addr; arlen = len; arsize = size; arbrust = burst; arvalid = 1;
        tmo = 0;
        @(negedge aclk);
        while (!arready && tmo < 50) begin tmo++; @(negedge aclk); end
        chk("ar_handshake", arready, 1'b1);
        @(posedge aclk);
        for (int n = 0; n <= int'(len); n++) begin
            a = m_addr(addr, len, size, burst, n);
            e.id   = id;
            e.last = (n == int'(len));
            if (err)            begin e.data = '0;        e.resp = 2'b10; end
            else if (a >= MEMB) begin e.data = '0;        e.resp = 2'b11; end
            else                begin e.data = m_word(a); e.resp = 2'b00; end
            exp_r.push_back(e);
        end
        #1 arvalid = 0;
        got = 0; tmo = 0;
        while (got < int'(len) + 1 && tmo < 200) begin
            rready = (mode == 0) ? 1'b1 : (mode == 1) ? tmo[0] : 1'($urandom_range(0, 1));
            @(negedge aclk);
            if (rvalid && rready) got++;
            @(posedge aclk); #1;
            tmo++;
            if (abort_after > 0 && got == abort_after) break;
        end
        rready = 0;
        if (abort_after == 0) chk("r_beat_count", got, int'(len) + 1);
    endtask

    task automatic clr_obs();
        obs_rdata.delete(); obs_rresp.delete(); obs_rlast.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0]  id, len;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nb, bw, sel;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_outs", {awready, wready, bvalid, bid, bresp, arready, rid, rdata, rresp,
                           rlast, rvalid}, 64'd0);
        @(posedge aclk); #1 arstn = 1;
        #1 chk("ready_before_edge", {awready, arready}, 2'b00);
        @(posedge aclk); #1 chk("ready_after_edge", {awready, arready}, 2'b11);

        // Prefill every word so the model knows the whole memory.
        for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 16; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
            do_write(4'(w), 32'(w * 64), 4'd15, 3'd2, 2'b01, 16, -1, 0, 0);
        end

        // INCR write then read.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hA0 + k; wstb[k] = 4'hF; end
        do_write(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 4, -1, 0, 1);
        chk("incr_bresp", obs_bresp, 2'b00);
        chk("mdl_incr_word3", m_word(32'h1C), 32'hA3);
        clr_obs();
        do_read(4'd7, 32'h10, 4'd3, 3'd2, 2'b01, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", obs_rdata[i], 32'hA0 + i);
            chk("incr_rlast", obs_rlast[i], i == 3);
        end

        // WRAP with backpressure: order 0x18, 0x1C, 0x10, 0x14.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hB0 + k; wstb[k] = 4'hF; end
        do_write(4'd2, 32'h18, 4'd3, 3'd2, 2'b10, 4, -1, 0, 0);
        chk("mdl_wrap_10", m_word(32'h10), 32'hB2);
        chk("mdl_wrap_14", m_word(32'h14), 32'hB3);
        clr_obs();
        do_read(4'd3, 32'h18, 4'd3, 3'd2, 2'b10, 1, 0);
        for (int i = 0; i < 4; i++) chk("wrap_rdata", obs_rdata[i], 32'hB0 + i);

        // Strobe: 0xFFFFFFFF with lanes 0 and 2 over zero.
        wdat[0] = 32'h0; wstb[0] = 4'hF;
        do_write(4'd1, 32'h0, 4'd0, 3'd2, 2'b01, 1, -1, 0, 0);
        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'b0101;
        do_write(4'd1, 32'h0, 4'd0, 3'd2, 2'b01, 1, -1, 0, 0);
        clr_obs();
        do_read(4'd1, 32'h0, 4'd0, 3'd2, 2'b01, 0, 0);
        chk("strobe_rdata", obs_rdata[0], 32'h00FF_00FF);

        // Error responses.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hD0 + k; wstb[k] = 4'hF; end
        do_write(4'd4, 32'(MEMB - 4), 4'd1, 3'd2, 2'b01, 2, -1, 0, 0);
        chk("decerr_bresp", obs_bresp, 2'b11);
        do_write(4'd4, 32'h40, 4'd1, 3'd2, 2'b11, 2, -1, 0, 0);
        chk("burst11_bresp", obs_bresp, 2'b10);
        do_read(4'd4, 32'h40, 4'd1, 3'd2, 2'b01, 0, 0);
        do_write(4'd6, 32'h80, 4'd3, 3'd2, 2'b01, 2, -1, 0, 0);
        chk("early_wlast_bresp", obs_bresp, 2'b10);
        do_write(4'd6, 32'h90, 4'd1, 3'd2, 2'b01, 2, 1, 0, 0);
        chk("bad_wid_bresp", obs_bresp, 2'b10);
        clr_obs();
        do_read(4'd8, 32'(MEMB), 4'd0, 3'd2, 2'b01, 0, 0);
        chk("oor_rresp", obs_rresp[0], 2'b11);
        chk("oor_rdata", obs_rdata[0], 32'h0);

        // Randomized serial traffic over the whole range, including past the end.
        for (int it = 0; it < 40; it++) begin
            id = 4'($urandom); len = 4'($urandom);
            size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            sel = $urandom_range(0, 9);
            burst = (sel < 1) ? 2'b11 : (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : 2'b10;
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 4'((2 << $urandom_range(0, 3)) - 1);
            addr = ($urandom_range(0, 9) == 0) ? $urandom_range(960, 1100) : $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 32; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
                nb = int'(len) + 1;
                sel = $urandom_range(0, 7);
                if (sel == 0 && nb > 1) nb--;
                if (sel == 1) nb++;
                bw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, nb - 1) : -1;
                do_write(id, addr, len, size, burst, nb, bw, 0, 1);
            end else begin
                do_read(id, addr, len, size, burst, $urandom_range(0, 2), 0);
            end
        end

        // Concurrent write (low half) and read (high half) channels.
        for (int it = 0; it < 20; it++) begin
            logic [31:0] wa, ra;
            logic [3:0]  wl, rl;
            logic [1:0]  wb, rb;
            wa = $urandom_range(0, 383); ra = $urandom_range(512, 1023);
            wl = 4'($urandom); rl = 4'($urandom);
            wb = 2'b01; rb = 2'($urandom_range(0, 2));
            if (rb == 2'b10) rl = 4'd7;
            for (int k = 0; k < 32; k++) begin wdat[k] = $urandom; wstb[k] = 4'($urandom); end
            fork
                do_write(4'(it), wa, wl, 3'd2, wb, int'(wl) + 1, -1, 0, 1);
                do_read(4'(it + 1), ra, rl, 3'd2, rb, 2, 0);
            join
        end

        // Reset in the middle of a write and a read burst.
        for (int k = 0; k < 4; k++) begin wdat[k] = 32'hC0 + k; wstb[k] = 4'hF; end
        fork
            do_write(4'd9, 32'h100, 4'd3, 3'd2, 2'b01, 4, -1, 2, 0);
            do_read(4'd9, 32'h200, 4'd3, 3'd2, 2'b01, 0, 1);
        join
        chk("mid_burst_active", {wready, rvalid}, 2'b11);
        arstn = 0;
        #1 chk("reset_kills_valids", {bvalid, rvalid, wready, awready, arready}, 5'd0);
        repeat (2) @(posedge aclk);
        exp_r.delete(); exp_b.delete();
        #1 arstn = 1;
        repeat (2) @(posedge aclk);
        #1;
        clr_obs();
        do_read(4'd10, 32'h100, 4'd3, 3'd2, 2'b01, 0, 0);
        chk("retained_beat0", obs_rdata[0], 32'hC0);
        chk("retained_beat1", obs_rdata[1], 32'hC1);
        for (int k = 0; k < 2; k++) begin wdat[k] = $urandom; wstb[k] = 4'hF; end
        do_write(4'd11, 32'h200, 4'd1, 3'd2, 2'b01, 2, -1, 0, 0);
        chk("post_reset_bresp", obs_bresp, 2'b00);
        do_read(4'd12, 32'h200, 4'd1, 3'd2, 2'b01, 2, 0);

        repeat (3) @(posedge aclk);
        chk("queues_drained", 32'(exp_r.size() + exp_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/axi_slv_mem.md
Name: axi_slv_mem

Overview:
- Synthesizable AXI3 slave (responder) backed by a word-addressed internal memory.
- Sits at the far end of axi_inf and answers the master driver's write and read bursts.
- Used as the default DUT and reference target for the master VIP.
- Write and read paths are independent FSMs, each with one outstanding transaction.

Parameters:
ID_WIDTH, 4, width of awid/wid/bid/arid/rid
ADDR_WIDTH, 32, address width
LEN_WIDTH, 4, awlen/arlen width (AXI3, max 16 beats)
SIZE_WIDTH, 3, awsize/arsize width
DATA_WIDTH, 32, data bus width; STRB = DATA_WIDTH/8
MEM_DEPTH, 256, memory words; valid byte range 0 .. MEM_DEPTH*STRB-1

Ports:
aclk  in  1  clock
arstn  in  1  asynchronous active-low reset
awid/awaddr/awlen/awsize  in  ID/ADDR/LEN/SIZE  write address channel fields
awbrust  in  2  burst type (00 FIXED, 01 INCR, 10 WRAP)
awlock/awcache/awprot  in  2/4/3  accepted, ignored
awvalid  in  1 ; awready  out  1  write address handshake
wid  in  ID ; wdata  in  DATA ; wstrob  in  STRB ; wlast  in  1 ; wvalid  in  1 ; wready  out  1
bid  out  ID ; bresp  out  2 ; bvalid  out  1 ; bready  in  1
arid/araddr/arlen/arsize/arbrust/arlock/arcache/arprot  in  same widths as AW
arvalid  in  1 ; arready  out  1
rid  out  ID ; rdata  out  DATA ; rresp  out  2 ; rlast  out  1 ; rvalid  out  1 ; rready  in  1

Behaviour:
- Clock and reset: single clock aclk. arstn is asynchronous and active-low.
- Reset values: all outputs 0.
  - awready and arready rise on the first aclk edge after arstn deasserts.
  - Memory contents are not reset.
- Reset mid-burst: both FSMs return to IDLE; in-flight bursts are dropped; completed memory writes are retained.
- Write FSM states: WIDLE, WDATA, WRESP.
  - WIDLE: awready=1. On awvalid&&awready, latch id, addr, len, size, burst, then go to WDATA.
  - WDATA: wready=1. Each wvalid&&wready beat writes the wdata byte lanes whose wstrob bit is 1 into mem[addr/STRB], then advances the address and beat count.
  - wlast accepted -> WRESP.
  - WRESP: bvalid=1 and bid=latched id. Outputs hold until bready, then return to WIDLE.
- Address rules (shared by both paths):
  - First beat address = latched address.
  - Subsequent beats = aligned address + (1<<size) for INCR.
  - FIXED: address unchanged.
  - WRAP: wraps within a (len+1)<<size byte boundary. Legal wrap len values are 1, 3, 7, 15.
- Error detection, evaluated at address accept:
  - SLVERR conditions: burst=11; (1<<size) > STRB; illegal wrap length.
  - On SLVERR, no beat of the burst writes memory.
- Per-beat errors:
  - Beat address outside range -> DECERR; that beat is not written.
  - wid != latched id -> SLVERR; beat is written.
  - wlast asserted on a beat other than beat len, or absent on beat len -> SLVERR. The burst ends on wlast regardless of count.
- bresp: sticky worst-case over the burst. Priority DECERR(11) > SLVERR(10) > OKAY(00). EXOKAY is never returned; exclusive access gets OKAY.
- Read FSM states: RIDLE, RDATA.
  - RIDLE: arready=1. On arvalid&&arready, latch fields, load beat 0 into the R output registers, and go to RDATA. First rvalid appears 1 cycle after the AR handshake.
  - RDATA: rvalid=1. rid, rdata, rresp and rlast stay stable while !rready.
  - On rvalid&&rready with !rlast: load the next beat in the same cycle, giving back-to-back throughput.
  - On rvalid&&rready with rlast: return to RIDLE with rvalid=0. arready is reasserted the following cycle.
- rresp is per beat:
  - Whole-burst SLVERR conditions as for writes, in which case rdata=0.
  - Out-of-range beat -> DECERR with rdata=0.
  - Otherwise OKAY.
- rlast=1 exactly on beat len.
- Narrow transfers:
  - Write: only wstrob lanes are written.
  - Read: the full word is returned.
- Same-word read/write collision: a read beat is loaded in the same cycle a write hits that word. The read returns the pre-write data.
- Write and read channels may complete simultaneously with no interaction.

Test Plan:
- Reset/idle: arstn low for 3 cycles, release -> all outputs 0 during reset; awready=arready=1 one cycle after release.
- INCR write then read:
  - Write awaddr=0x10, awlen=3, awsize=2, awbrust=01, wdata=0xA0..0xA3, wstrob=F -> bresp=00, bid=awid.
  - Read same address -> 4 beats 0xA0..0xA3, rresp=00, rlast only on beat 4.
- WRAP with backpressure:
  - Write awaddr=0x18, awlen=3, awsize=2, awbrust=10 -> words written at 0x18, 0x1C, 0x10, 0x14.
  - Read back with rready toggled every other cycle -> rdata stable while stalled, wrap order preserved.
- Strobe and narrow:
  - Write 0xFFFFFFFF with wstrob=4'b0101 over 0x00000000 -> read returns 0x00FF00FF.
- Errors:
  - awaddr=MEM_DEPTH*4-4, awlen=1 -> bresp=11, second beat not written.
  - awbrust=11 -> bresp=10, memory unchanged.
  - Early wlast on beat 2 of awlen=3 -> bresp=10.
  - Read out of range -> rresp=11, rdata=0.
- Reset mid-burst: assert arstn during beat 2 of a 4-beat read and during WDATA of a write -> bvalid=rvalid=0 immediately; next transactions complete normally; earlier written words are retained.
